// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline memory stage.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam logic [3:0] BE_WORD  = 4'hF;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;

endpackage

// File: rtl/dmem_ctrl_store_align.sv
// Byte-lane formatter for stores: replicates byte data across lanes, builds the
// byte enables and flags word accesses that are not word-aligned.
module store_align
    import mips_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic        sb_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic        misalign_o
);

    always_comb begin
        wdata_o    = wdata_i;
        be_o       = BE_WORD;
        misalign_o = |addr_i;
        if (sb_i) begin
            wdata_o    = {4{wdata_i[7:0]}};
            be_o       = BE_BYTE0 << addr_i;
            misalign_o = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// M-stage data-memory controller: one req/ack bus transaction per load/store,
// stalling the pipeline while outstanding and flagging timeout/misalignment.
module dmem_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic        sbM,
    input  logic [31:0] addrM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        buserr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    dmem_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;

    logic        access, is_store;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;
    logic        misalign;

    assign access   = memreadM | memwriteM;
    assign is_store = memwriteM;

    store_align u_align (
        .addr_i     (addrM[1:0]),
        .sb_i       (sbM & memwriteM),
        .wdata_i    (writedataM),
        .wdata_o    (fmt_wdata),
        .be_o       (fmt_be),
        .misalign_o (misalign)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misalign) begin
                        // No bus cycle: loads see zero, stores are dropped.
                        err_d   = 1'b1;
                        state_d = DONE;
                        if (!is_store) rdata_d = 32'h0;
                    end else begin
                        state_d = REQ;
                        cnt_d   = 8'd0;
                        we_d    = is_store;
                        addr_d  = {addrM[31:2], 2'b00};
                        wdata_d = fmt_wdata;
                        be_d    = is_store ? fmt_be : BE_WORD;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    if (!we_q) rdata_d = bus_rdata;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (!we_q) rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign stallM    = ((state_q == IDLE) & access) | (state_q == REQ);
    assign readdataM = rdata_q;
    assign buserr    = err_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;

endmodule
